// File: rtl/dot_product_acc_pkg.sv
// Shared types, defaults and helpers for the dot-product accumulator.
package dot_product_acc_pkg;

  typedef enum logic {
    ST_ACC  = 1'b0,
    ST_HOLD = 1'b1
  } state_e;

  localparam int unsigned DEF_PROD_W = 8;
  localparam int unsigned DEF_ACC_W  = 16;
  localparam int unsigned DEF_LEN    = 4;

  // Beat counter width; a single-beat result still needs one bit of storage.
  function automatic int unsigned cnt_width(input int unsigned len);
    return (len > 1) ? $clog2(len) : 1;
  endfunction

  // Team full-adder cell: returns {carry_out, sum}.
  function automatic logic [1:0] full_add(input logic a, input logic b, input logic ci);
    return {(a & b) | (ci & (a ^ b)), a ^ b ^ ci};
  endfunction

endpackage

// File: rtl/dot_product_acc_if.sv
// Product input stream and result output port of the dot-product accumulator.
interface dot_product_acc_if
  import dot_product_acc_pkg::*;
#(
  parameter int unsigned PROD_W = DEF_PROD_W,
  parameter int unsigned ACC_W  = DEF_ACC_W
);

  logic              prod_valid;
  logic              prod_ready;
  logic [PROD_W-1:0] product;
  logic              out_valid;
  logic              out_ready;
  logic [ACC_W-1:0]  out_sum;
  logic              out_ovf;

  modport master (
    output prod_valid, product, out_ready,
    input  prod_ready, out_valid, out_sum, out_ovf
  );

  modport slave (
    input  prod_valid, product, out_ready,
    output prod_ready, out_valid, out_sum, out_ovf
  );

endinterface

// File: rtl/dot_product_acc_adder.sv
// Ripple-carry adder built from the full-adder cell; carry-out feeds overflow.
module acc_adder
  import dot_product_acc_pkg::*;
#(
  parameter int unsigned W = DEF_ACC_W
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] sum,
  output logic         cout
);

  logic carry;

  always_comb begin : p_ripple
    sum   = '0;
    carry = 1'b0;
    for (int i = 0; i < int'(W); i++) begin
      {carry, sum[i]} = full_add(a[i], b[i], carry);
    end
    cout = carry;
  end

endmodule

// File: rtl/dot_product_acc.sv
// Accumulates LEN unsigned products into one sum and offers it on a
// valid/ready port with a sticky per-result overflow flag.
module dot_product_acc
  import dot_product_acc_pkg::*;
#(
  parameter int unsigned PROD_W = DEF_PROD_W,
  parameter int unsigned ACC_W  = DEF_ACC_W,
  parameter int unsigned LEN    = DEF_LEN
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  dot_product_acc_if.slave  bus
);

  localparam int unsigned CNT_W = cnt_width(LEN);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LEN - 1);

  state_e            state;
  logic [ACC_W-1:0]  acc;
  logic [CNT_W-1:0]  cnt;
  logic              ovf;
  logic [PROD_W-1:0] prod;
  logic [ACC_W-1:0]  add_sum;
  logic              add_cout;
  logic              take;

  assign prod = bus.product;
  assign take = bus.prod_valid & bus.prod_ready;

  acc_adder #(.W(ACC_W)) u_acc_adder (
    .a    (acc),
    .b    (ACC_W'(prod)),
    .sum  (add_sum),
    .cout (add_cout)
  );

  // clear outranks every other event, including a pending result in HOLD.
  always_ff @(posedge clk or negedge rst_n) begin : p_fsm
    if (!rst_n) begin
      state          <= ST_ACC;
      acc            <= '0;
      cnt            <= '0;
      ovf            <= 1'b0;
      bus.prod_ready <= 1'b0;
      bus.out_valid  <= 1'b0;
      bus.out_sum    <= '0;
      bus.out_ovf    <= 1'b0;
    end else if (clear) begin
      state          <= ST_ACC;
      acc            <= '0;
      cnt            <= '0;
      ovf            <= 1'b0;
      bus.prod_ready <= 1'b0;
      bus.out_valid  <= 1'b0;
    end else begin
      case (state)
        ST_ACC: begin
          bus.prod_ready <= 1'b1;
          if (take) begin
            if (cnt == CNT_LAST) begin
              bus.out_sum    <= add_sum;
              bus.out_ovf    <= ovf | add_cout;
              bus.out_valid  <= 1'b1;
              bus.prod_ready <= 1'b0;
              acc            <= '0;
              cnt            <= '0;
              ovf            <= 1'b0;
              state          <= ST_HOLD;
            end else begin
              acc <= add_sum;
              ovf <= ovf | add_cout;
              cnt <= cnt + CNT_W'(1);
            end
          end
        end
        ST_HOLD: begin
          // prod_ready stays low through the handshake cycle: one bubble minimum.
          if (bus.out_ready) begin
            bus.out_valid  <= 1'b0;
            bus.prod_ready <= 1'b1;
            state          <= ST_ACC;
          end
        end
        default: state <= ST_ACC;
      endcase
    end
  end

endmodule

// File: tb/tb_dot_product_acc.sv
// Bench for dot_product_acc: default instance (16-bit, LEN=4) and a narrow
// instance (10-bit, LEN=8), checked against an arithmetic sum/overflow model.
module tb_dot_product_acc;

  logic clk = 1'b0;
  logic rst_n;
  logic clear_a;
  logic clear_b;

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  dot_product_acc_if #(.PROD_W(8), .ACC_W(16)) a_if ();
  dot_product_acc_if #(.PROD_W(8), .ACC_W(10)) b_if ();

  dot_product_acc #(.PROD_W(8), .ACC_W(16), .LEN(4)) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (clear_a),
    .bus   (a_if)
  );

  dot_product_acc #(.PROD_W(8), .ACC_W(10), .LEN(8)) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (clear_b),
    .bus   (b_if)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp)
    else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic rdy(input bit b);
    return b ? b_if.prod_ready : a_if.prod_ready;
  endfunction

  function automatic logic ovalid(input bit b);
    return b ? b_if.out_valid : a_if.out_valid;
  endfunction

  function automatic logic [31:0] osum(input bit b);
    return b ? 32'(b_if.out_sum) : 32'(a_if.out_sum);
  endfunction

  function automatic logic oovf(input bit b);
    return b ? b_if.out_ovf : a_if.out_ovf;
  endfunction

  task automatic drive(input bit b, input bit v, input int unsigned p);
    if (b) begin
      b_if.prod_valid = v;
      b_if.product    = 8'(p);
    end else begin
      a_if.prod_valid = v;
      a_if.product    = 8'(p);
    end
  endtask

  // Offer one beat, wait (bounded) for prod_ready, then let it be taken.
  task automatic beat(input bit b, input int unsigned p);
    int cyc = 0;
    drive(b, 1'b1, p);
    while (!rdy(b) && cyc < 50) begin
      tick();
      cyc++;
    end
    chk("beat_ready", 32'(rdy(b)), 32'd1);
    tick();
    drive(b, 1'b0, $urandom_range(0, 255));
  endtask

  // Model: the wrapped sum of all beats; overflow iff the true total reached 2^W.
  task automatic expect_result(input bit b, input int unsigned total, input string tag);
    int unsigned w = b ? 10 : 16;
    logic [31:0] lim = 32'd1 << w;
    chk({tag, "_valid"}, 32'(ovalid(b)), 32'd1);
    chk({tag, "_sum"}, osum(b), total % lim);
    chk({tag, "_ovf"}, 32'(oovf(b)), (total >= lim) ? 32'd1 : 32'd0);
  endtask

  task automatic send_random(input bit b, input int unsigned n, input int unsigned lo,
                             input int unsigned hi, output int unsigned total);
    total = 0;
    for (int i = 0; i < int'(n); i++) begin
      int unsigned p = $urandom_range(hi, lo);
      total += p;
      beat(b, p);
      if (i < int'(n) - 1) begin
        repeat ($urandom_range(0, 2)) begin
          drive(b, 1'b0, $urandom_range(0, 255));
          tick();
        end
      end
    end
  endtask

  initial begin
    int unsigned total;
    bit stall;
    rst_n   = 1'b0;
    clear_a = 1'b0;
    clear_b = 1'b0;
    drive(1'b0, 1'b0, 0);
    drive(1'b1, 1'b0, 0);
    a_if.out_ready = 1'b1;
    b_if.out_ready = 1'b1;
    tick();
    tick();

    // Reset state and prod_ready rising one edge after release
    chk("rst_prod_ready", 32'(a_if.prod_ready), 32'd0);
    chk("rst_out_valid", 32'(a_if.out_valid), 32'd0);
    chk("rst_out_sum", osum(1'b0), 32'd0);
    chk("rst_out_ovf", 32'(a_if.out_ovf), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rel_ready_low", 32'(a_if.prod_ready), 32'd0);
    tick();
    chk("rel_ready_high", 32'(a_if.prod_ready), 32'd1);

    // 1: back-to-back beats, single-cycle latency
    beat(1'b0, 3);
    beat(1'b0, 5);
    beat(1'b0, 7);
    chk("t1_early_valid", 32'(a_if.out_valid), 32'd0);
    beat(1'b0, 9);
    expect_result(1'b0, 24, "t1");
    tick();
    chk("t1_valid_drop", 32'(a_if.out_valid), 32'd0);
    chk("t1_ready_back", 32'(a_if.prod_ready), 32'd1);

    // 2: idle gaps do not advance the count
    for (int i = 0; i < 4; i++) begin
      beat(1'b0, 255);
      if (i < 3) begin
        repeat (2) begin
          drive(1'b0, 1'b0, $urandom_range(0, 255));
          tick();
        end
        chk("t2_no_early", 32'(a_if.out_valid), 32'd0);
      end
    end
    expect_result(1'b0, 1020, "t2");
    tick();

    // 3: downstream stall holds the result and blocks new beats
    a_if.out_ready = 1'b0;
    beat(1'b0, 1);
    beat(1'b0, 2);
    beat(1'b0, 3);
    beat(1'b0, 4);
    expect_result(1'b0, 10, "t3");
    drive(1'b0, 1'b1, 99);
    repeat (5) begin
      tick();
      chk("t3_hold_valid", 32'(a_if.out_valid), 32'd1);
      chk("t3_hold_sum", osum(1'b0), 32'd10);
      chk("t3_hold_ready", 32'(a_if.prod_ready), 32'd0);
    end
    a_if.out_ready = 1'b1;
    tick();
    chk("t3_hs_valid", 32'(a_if.out_valid), 32'd0);
    chk("t3_hs_ready", 32'(a_if.prod_ready), 32'd1);
    tick();
    drive(1'b0, 1'b0, 0);
    beat(1'b0, 1);
    beat(1'b0, 1);
    beat(1'b0, 1);
    expect_result(1'b0, 102, "t3_next");
    tick();

    // 4: narrow accumulator wraps and flags overflow
    for (int i = 0; i < 8; i++) begin
      beat(1'b1, 255);
      if (i == 3) chk("t4_len8", 32'(b_if.out_valid), 32'd0);
    end
    expect_result(1'b1, 2040, "t4_ovf");
    tick();
    for (int i = 0; i < 8; i++) beat(1'b1, 1);
    expect_result(1'b1, 8, "t4_clean");
    tick();

    // 5: clear aborts accumulation (coinciding beat discarded) and drops HOLD
    beat(1'b0, 10);
    beat(1'b0, 20);
    clear_a = 1'b1;
    drive(1'b0, 1'b1, 50);
    tick();
    clear_a = 1'b0;
    drive(1'b0, 1'b0, 0);
    chk("t5_clr_ready", 32'(a_if.prod_ready), 32'd0);
    tick();
    chk("t5_clr_ready_back", 32'(a_if.prod_ready), 32'd1);
    for (int i = 0; i < 4; i++) beat(1'b0, 1);
    expect_result(1'b0, 4, "t5");
    tick();
    a_if.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) beat(1'b0, 5);
    expect_result(1'b0, 20, "t5_hold");
    clear_a = 1'b1;
    tick();
    clear_a = 1'b0;
    chk("t5_hold_drop", 32'(a_if.out_valid), 32'd0);
    chk("t5_hold_ready", 32'(a_if.prod_ready), 32'd0);
    tick();
    chk("t5_after_ready", 32'(a_if.prod_ready), 32'd1);
    a_if.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) beat(1'b0, 7);
    expect_result(1'b0, 28, "t5_after");
    tick();

    // 6: asynchronous reset in HOLD
    a_if.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) beat(1'b0, i + 1);
    expect_result(1'b0, 10, "t6_pre");
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_ready", 32'(a_if.prod_ready), 32'd0);
    chk("t6_rst_valid", 32'(a_if.out_valid), 32'd0);
    chk("t6_rst_sum", osum(1'b0), 32'd0);
    chk("t6_rst_ovf", 32'(a_if.out_ovf), 32'd0);
    tick();
    @(negedge clk);
    rst_n = 1'b1;
    a_if.out_ready = 1'b1;
    #1;
    chk("t6_rel_low", 32'(a_if.prod_ready), 32'd0);
    tick();
    chk("t6_rel_high", 32'(a_if.prod_ready), 32'd1);
    for (int i = 0; i < 4; i++) beat(1'b0, 2);
    expect_result(1'b0, 8, "t6");
    tick();

    // Randomized results with random gaps and downstream stalls
    for (int r = 0; r < 8; r++) begin
      stall = 1'($urandom_range(0, 1));
      a_if.out_ready = !stall;
      send_random(1'b0, 4, 0, 255, total);
      expect_result(1'b0, total, "rnd_a");
      if (stall) begin
        repeat ($urandom_range(1, 4)) begin
          tick();
          chk("rnd_a_stable", osum(1'b0), total % 32'h10000);
        end
        a_if.out_ready = 1'b1;
      end
      tick();
      chk("rnd_a_drop", 32'(a_if.out_valid), 32'd0);
    end
    for (int r = 0; r < 6; r++) begin
      send_random(1'b1, 8, 60, 255, total);
      expect_result(1'b1, total, "rnd_b");
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
